// File: rtl/delaychain_bist.sv
// ============================================================================
// Module      : delaychain_bist
// Description : Multi-channel flop delay chain with tap-selectable delay and
//               an LFSR-driven built-in self-test with mismatch counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delaychain_bist #(
    parameter int          CH      = 8,
    parameter int          DEPTH   = 64,
    parameter int          RUN_LEN = 1024,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          ERRW    = 16,
    parameter int          TAPW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   din,
    input  logic [TAPW-1:0] tap_sel,
    input  logic            test,
    input  logic            start,
    input  logic            inject,
    output logic [CH-1:0]   dout,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt
);

    localparam logic [15:0]     c_seed    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int              c_cntw    = $clog2(RUN_LEN + DEPTH + 1);
    localparam int              c_popw    = $clog2(CH + 1);
    localparam int              c_sumw    = ERRW + 1;
    localparam logic [TAPW-1:0] c_tap_max = TAPW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH-1:0]     r_stage [DEPTH];
    logic [TAPW-1:0]   r_tap;
    logic [15:0]       r_gen;
    logic [15:0]       r_chk;
    logic [c_cntw-1:0] r_cnt;
    logic [ERRW-1:0]   r_err;
    logic              r_done;
    logic              r_pass;

    logic [c_cntw-1:0] w_cnt_nxt;
    logic              w_latch;
    logic              w_clr_err;
    logic              w_acc;
    logic [TAPW-1:0]   w_tap_in;
    logic [TAPW-1:0]   w_eff_tap;
    logic [CH-1:0]     w_src;
    logic [CH-1:0]     w_diff;
    logic [c_popw-1:0] w_pop;
    logic [c_sumw-1:0] w_sum;
    logic [ERRW-1:0]   w_err_nxt;
    logic              w_active_cur;
    logic              w_active_nxt;

    assign w_tap_in  = (tap_sel > c_tap_max) ? c_tap_max : tap_sel;
    assign w_eff_tap = test ? r_tap : w_tap_in;
    assign w_src     = (test ? r_gen[CH-1:0] : din) ^ CH'(inject);

    assign dout    = r_stage[w_eff_tap];
    assign busy    = (r_state == S_FILL) || (r_state == S_RUN);
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_stage[j] <= '0;
            end
        end else begin
            r_stage[0] <= w_src;
            for (int j = 1; j < DEPTH; j++) begin
                r_stage[j] <= r_stage[j-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_clr_err   = 1'b0;
        w_acc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (test && start) begin
                    w_state_nxt = S_FILL;
                    w_latch     = 1'b1;
                    w_clr_err   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_FILL: begin
                if (!test) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_cntw'(r_tap)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cntw'(1);
                end
            end
            S_RUN: begin
                if (!test) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc = 1'b1;
                    if (r_cnt == c_cntw'(RUN_LEN - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cntw'(1);
                    end
                end
            end
            S_DONE: begin
                if (!test) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_FILL;
                    w_latch     = 1'b1;
                    w_clr_err   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pattern sources only free-run while a test stays in progress; any entry
    // into FILL or RUN from elsewhere therefore starts from the seed.
    assign w_active_cur = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_active_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);

    assign w_diff = dout ^ r_chk[CH-1:0];

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + c_popw'(w_diff[i]);
        end
    end

    assign w_sum = {1'b0, r_err} + c_sumw'(w_pop);

    always_comb begin
        w_err_nxt = r_err;
        if (w_clr_err) begin
            w_err_nxt = '0;
        end else if (w_acc) begin
            w_err_nxt = w_sum[ERRW] ? {ERRW{1'b1}} : w_sum[ERRW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap  <= '0;
            r_gen  <= c_seed;
            r_chk  <= c_seed;
            r_cnt  <= '0;
            r_err  <= '0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_err  <= w_err_nxt;
            r_done <= (w_state_nxt == S_DONE);
            r_pass <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
            if (w_latch) begin
                r_tap <= w_tap_in;
            end
            r_gen <= (w_active_cur && w_active_nxt) ? lfsr_step(r_gen) : c_seed;
            r_chk <= ((r_state == S_RUN) && (w_state_nxt == S_RUN)) ? lfsr_step(r_chk) : c_seed;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delaychain_bist.sv
// ============================================================================
// Module      : tb_delaychain_bist
// Description : Self-checking bench for delaychain_bist (delay taps and BIST).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delaychain_bist;

    localparam int DEPTH   = 64;
    localparam int RUN_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic [5:0]  tap_sel;
    logic        test, start, inject;
    logic [7:0]  dout;
    logic        busy, done, pass;
    logic [15:0] err_cnt;

    logic        test48, start48;
    logic [7:0]  dout48;
    logic        busy48, done48, pass48;
    logic [15:0] err48;

    logic        test_s, start_s, inject_s;
    logic [1:0]  tap_s;
    logic [7:0]  din_s;
    logic [7:0]  dout_s;
    logic        busy_s, done_s, pass_s;
    logic [5:0]  err_s;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [7:0]  hist [0:16383];

    always #5 clk = ~clk;

    delaychain_bist dut (
        .clk(clk), .rst_n(rst_n), .din(din), .tap_sel(tap_sel), .test(test),
        .start(start), .inject(inject), .dout(dout), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt)
    );

    delaychain_bist #(.DEPTH(48), .RUN_LEN(64)) dut48 (
        .clk(clk), .rst_n(rst_n), .din(din), .tap_sel(tap_sel), .test(test48),
        .start(start48), .inject(inject), .dout(dout48), .busy(busy48), .done(done48),
        .pass(pass48), .err_cnt(err48)
    );

    delaychain_bist #(.DEPTH(4), .RUN_LEN(100), .ERRW(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .din(din_s), .tap_sel(tap_s), .test(test_s),
        .start(start_s), .inject(inject_s), .dout(dout_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .err_cnt(err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // History holds the chain input presented in each cycle
    task automatic tick();
        hist[cyc % 16384] = din ^ {7'b0, inject};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic flush(input int n);
        din    = '0;
        inject = 1'b0;
        repeat (n) tick();
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // A fault presented at generator index k is compared in RUN cycle k
    task automatic run_bist(input int tap, input int inj_a, input int inj_b, input bit rnd,
                            input int abort_at, output int n, output int exp_err);
        int e;
        e       = min_i(tap, DEPTH - 1);
        test    = 1'b1;
        tap_sel = 6'(tap);
        start   = 1'b1;
        inject  = 1'b0;
        tick();
        start   = 1'b0;
        n       = 0;
        exp_err = 0;
        while (busy === 1'b1 && n < 5000) begin
            inject = (n == inj_a) || (n == inj_b) || (rnd && ($urandom_range(0, 39) == 0));
            if (abort_at >= 0 && n == abort_at) test = 1'b0;
            if (inject && n < RUN_LEN && (abort_at < 0 || n < abort_at - e - 1)) exp_err++;
            tap_sel = 6'($urandom_range(0, 63));
            start   = ($urandom_range(0, 15) == 0);
            din     = 8'($urandom);
            n++;
            tick();
        end
        inject = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat48, lat64, n, ee, ns, tap, e, e48;
        logic [7:0] v48, v64;

        rst_n = 1'b0; din = '0; tap_sel = '0; test = 1'b0; start = 1'b0; inject = 1'b0;
        test48 = 1'b0; start48 = 1'b0;
        test_s = 1'b0; start_s = 1'b0; inject_s = 1'b0; tap_s = '0; din_s = '0;
        cyc = 0;
        for (int i = 0; i < 16384; i++) hist[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_pass", 32'(pass), 32'h0);
        chk("reset_err", 32'(err_cnt), 32'h0);
        chk("reset_dout48", 32'(dout48), 32'h0);
        rst_n = 1'b1;
        cyc   = 100;

        // T1: minimum delay and single-cycle pulse width
        tap_sel = 6'd0;
        din     = 8'h01;
        tick();
        chk("t1_tap0_on", 32'(dout[0]), 32'h1);
        din = 8'h00;
        tick();
        chk("t1_tap0_off", 32'(dout[0]), 32'h0);
        flush(70);

        tap_sel = 6'd63;
        din     = 8'h01;
        lat     = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            din = 8'h00;
            #1;
            if (lat < 0 && dout[0] === 1'b1) lat = i;
        end
        chk("t1_tap63_latency", 32'(lat), 32'd64);
        flush(80);

        // T2: clamping on the 48-deep build
        tap_sel = 6'd60;
        din     = 8'hA5;
        lat48 = -1; lat64 = -1; v48 = '0; v64 = '0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            din = 8'h00;
            #1;
            if (lat48 < 0 && dout48 !== 8'h00) begin lat48 = i; v48 = dout48; end
            if (lat64 < 0 && dout !== 8'h00) begin lat64 = i; v64 = dout; end
        end
        chk("t2_clamp_latency48", 32'(lat48), 32'd48);
        chk("t2_clamp_value48", 32'(v48), 32'hA5);
        chk("t2_tap60_latency64", 32'(lat64), 32'd61);
        chk("t2_tap60_value64", 32'(v64), 32'hA5);
        flush(80);

        // Random functional traffic with live tap changes and injection
        for (int i = 0; i < 300; i++) begin
            din     = 8'($urandom);
            tap_sel = 6'($urandom_range(0, 63));
            inject  = ($urandom_range(0, 9) == 0);
            #1;
            e   = int'(tap_sel);
            e48 = min_i(int'(tap_sel), 47);
            chk("fn_dout", 32'(dout), 32'(hist[(cyc - e - 1) % 16384]));
            chk("fn_dout48", 32'(dout48), 32'(hist[(cyc - e48 - 1) % 16384]));
            tick();
        end
        inject = 1'b0;

        // T3: clean self-test
        run_bist(5, -1, -1, 1'b0, -1, n, ee);
        chk("t3_busy_cycles", 32'(n), 32'd1030);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_pass", 32'(pass), 32'h1);
        chk("t3_err", 32'(err_cnt), 32'h0);
        tick();
        chk("t3_done_hold", 32'(done), 32'h1);

        // T4: fault in RUN cycle 10 is counted, in RUN cycle 1020 is not
        run_bist(5, 5 + 1 + 10, -1, 1'b0, -1, n, ee);
        chk("t4_run10_err", 32'(err_cnt), 32'(ee));
        chk("t4_run10_pass", 32'(pass), 32'h0);
        run_bist(5, 5 + 1 + 1020, -1, 1'b0, -1, n, ee);
        chk("t4_run1020_err", 32'(err_cnt), 32'h0);
        chk("t4_run1020_pass", 32'(pass), 32'h1);
        run_bist(5, 2, -1, 1'b0, -1, n, ee);
        chk("t4_fill_err", 32'(err_cnt), 32'h1);

        // Random taps and random faults
        for (int r = 0; r < 3; r++) begin
            tap = $urandom_range(0, 63);
            run_bist(tap, -1, -1, 1'b1, -1, n, ee);
            chk("rnd_busy_cycles", 32'(n), 32'(min_i(tap, DEPTH - 1) + 1 + RUN_LEN));
            chk("rnd_err", 32'(err_cnt), 32'(ee));
            chk("rnd_pass", 32'(pass), 32'(ee == 0));
            chk("rnd_done", 32'(done), 32'h1);
        end

        // T5: abort in RUN cycle 100 keeps err_cnt, then a clean rerun
        run_bist(5, 5 + 1 + 10, -1, 1'b0, 5 + 1 + 100, n, ee);
        chk("t5_abort_cycles", 32'(n), 32'd107);
        chk("t5_abort_busy", 32'(busy), 32'h0);
        chk("t5_abort_done", 32'(done), 32'h0);
        chk("t5_abort_pass", 32'(pass), 32'h0);
        chk("t5_abort_err_hold", 32'(err_cnt), 32'(ee));
        run_bist(5, -1, -1, 1'b0, -1, n, ee);
        chk("t5_rerun_cycles", 32'(n), 32'd1030);
        chk("t5_rerun_pass", 32'(pass), 32'h1);
        chk("t5_rerun_err", 32'(err_cnt), 32'h0);

        // Saturation on a 6-bit counter: every cycle faulted, 100 compares
        test_s   = 1'b1;
        tap_s    = 2'd3;
        start_s  = 1'b1;
        inject_s = 1'b1;
        tick();
        start_s = 1'b0;
        ns = 0;
        while (busy_s === 1'b1 && ns < 500) begin
            ns++;
            tick();
        end
        inject_s = 1'b0;
        chk("sat_busy_cycles", 32'(ns), 32'd104);
        chk("sat_err", 32'(err_s), 32'd63);
        chk("sat_pass", 32'(pass_s), 32'h0);
        chk("sat_done", 32'(done_s), 32'h1);

        // T6: asynchronous reset in the middle of RUN
        test    = 1'b1;
        tap_sel = 6'd5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        chk("t6_busy_before", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_dout", 32'(dout), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_done", 32'(done), 32'h0);
        chk("t6_async_pass", 32'(pass), 32'h0);
        chk("t6_async_err", 32'(err_cnt), 32'h0);
        test = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_idle_after", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
